// File: rtl/cheshire_pkg.sv
// rtl/cheshire_pkg.sv - shared types and default addresses for the boot sequencer
package cheshire_pkg;

    localparam logic [47:0] ScratchRegsBase = 48'h0300_0000;
    localparam logic [47:0] LlcCfgBase      = 48'h0300_1000;

    localparam logic [47:0] BootLlcCfgAddr  = LlcCfgBase;
    localparam logic [47:0] BootEntryAddr   = ScratchRegsBase;
    localparam logic [47:0] BootStartAddr   = ScratchRegsBase + 48'h8;
    localparam logic [47:0] BootEocAddr     = ScratchRegsBase + 48'h4 + 48'h10;

    typedef logic [3:0] boot_seq_state_e;

    localparam boot_seq_state_e ST_IDLE        = 4'd0;
    localparam boot_seq_state_e ST_WAIT_BIST   = 4'd1;
    localparam boot_seq_state_e ST_CFG_LLC     = 4'd2;
    localparam boot_seq_state_e ST_WR_ENTRY_LO = 4'd3;
    localparam boot_seq_state_e ST_WR_ENTRY_HI = 4'd4;
    localparam boot_seq_state_e ST_WR_START    = 4'd5;
    localparam boot_seq_state_e ST_POLL_WAIT   = 4'd6;
    localparam boot_seq_state_e ST_POLL_RD     = 4'd7;
    localparam boot_seq_state_e ST_DONE        = 4'd8;
    localparam boot_seq_state_e ST_ERROR       = 4'd9;

    typedef enum logic [1:0] {
        ERR_NONE = 2'd0,
        ERR_BIST = 2'd1,
        ERR_BUS  = 2'd2
    } err_code_e;

endpackage

// File: rtl/cheshire_boot_seq_bus_if.sv
// rtl/cheshire_boot_seq_bus_if.sv - single-outstanding register-bus request/response engine
module cheshire_boot_seq_bus_if #(
    parameter int unsigned AddrWidth = 48,
    parameter int unsigned DataWidth = 32
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 issue_i,
    input  logic                 write_i,
    input  logic [AddrWidth-1:0] addr_i,
    input  logic [DataWidth-1:0] wdata_i,
    output logic                 req_valid_o,
    output logic                 req_write_o,
    output logic [AddrWidth-1:0] req_addr_o,
    output logic [DataWidth-1:0] req_wdata_o,
    input  logic                 req_ready_i,
    input  logic                 rsp_valid_i,
    input  logic [DataWidth-1:0] rsp_rdata_i,
    input  logic                 rsp_error_i,
    output logic                 idle_o,
    output logic                 rsp_done_o,
    output logic                 rsp_err_o,
    output logic [DataWidth-1:0] rsp_rdata_o
);

    logic wait_q;
    logic accept;

    // A response in the acceptance cycle itself is consumed as well.
    assign accept      = req_valid_o && req_ready_i;
    assign rsp_done_o  = rsp_valid_i && (wait_q || accept);
    assign rsp_err_o   = rsp_done_o && rsp_error_i;
    assign rsp_rdata_o = rsp_rdata_i;
    assign idle_o      = !req_valid_o && !wait_q;

    // Request registers: load on issue, hold until accepted, then wait for the response.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            req_valid_o <= 1'b0;
            req_write_o <= 1'b0;
            req_addr_o  <= '0;
            req_wdata_o <= '0;
            wait_q      <= 1'b0;
        end else if (idle_o && issue_i) begin
            req_valid_o <= 1'b1;
            req_write_o <= write_i;
            req_addr_o  <= addr_i;
            req_wdata_o <= wdata_i;
        end else if (accept) begin
            req_valid_o <= 1'b0;
            wait_q      <= !rsp_valid_i;
        end else if (rsp_done_o) begin
            wait_q      <= 1'b0;
        end
    end

endmodule

// File: rtl/cheshire_boot_seq.sv
// rtl/cheshire_boot_seq.sv - hardware boot sequencer: BIST wait, LLC/SPM setup, entry/start writes, EOC polling
module cheshire_boot_seq
    import cheshire_pkg::*;
#(
    parameter int unsigned          AddrWidth   = 48,
    parameter int unsigned          DataWidth   = 32,
    parameter logic [AddrWidth-1:0] LlcCfgAddr  = AddrWidth'(BootLlcCfgAddr),
    parameter logic [DataWidth-1:0] LlcSpmMask  = DataWidth'(32'h0000_00ff),
    parameter logic [AddrWidth-1:0] EntryAddr   = AddrWidth'(BootEntryAddr),
    parameter logic [AddrWidth-1:0] StartAddr   = AddrWidth'(BootStartAddr),
    parameter logic [AddrWidth-1:0] EocAddr     = AddrWidth'(BootEocAddr),
    parameter int unsigned          PollCycles  = 1024,
    parameter int unsigned          BistTimeout = 65535
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 start_i,
    input  logic [63:0]          entry_i,
    input  logic                 bist_done_i,
    output logic                 req_valid_o,
    output logic                 req_write_o,
    output logic [AddrWidth-1:0] req_addr_o,
    output logic [DataWidth-1:0] req_wdata_o,
    input  logic                 req_ready_i,
    input  logic                 rsp_valid_i,
    input  logic [DataWidth-1:0] rsp_rdata_i,
    input  logic                 rsp_error_i,
    output logic                 busy_o,
    output logic                 done_o,
    output logic [DataWidth-2:0] exit_status_o,
    output logic                 err_o,
    output logic [1:0]           err_code_o
);

    boot_seq_state_e      state_q;
    boot_seq_state_e      bus_next;
    logic [63:0]          entry_q;
    logic [31:0]          cnt_q;
    logic                 done_q;
    logic [DataWidth-2:0] exit_status_q;
    err_code_e            err_code_q;

    logic                 issue;
    logic                 req_write_d;
    logic [AddrWidth-1:0] req_addr_d;
    logic [DataWidth-1:0] req_wdata_d;
    logic                 bus_idle;
    logic                 bus_done;
    logic                 bus_err;
    logic [DataWidth-1:0] bus_rdata;

    // Each bus state issues its transfer once the engine is idle and names its successor.
    always_comb begin
        issue       = 1'b0;
        req_write_d = 1'b1;
        req_addr_d  = '0;
        req_wdata_d = '0;
        bus_next    = ST_IDLE;
        case (state_q)
            ST_CFG_LLC: begin
                issue       = bus_idle;
                req_addr_d  = LlcCfgAddr;
                req_wdata_d = LlcSpmMask;
                bus_next    = ST_WR_ENTRY_LO;
            end
            ST_WR_ENTRY_LO: begin
                issue       = bus_idle;
                req_addr_d  = EntryAddr;
                req_wdata_d = entry_q[31:0];
                bus_next    = ST_WR_ENTRY_HI;
            end
            ST_WR_ENTRY_HI: begin
                issue       = bus_idle;
                req_addr_d  = EntryAddr + AddrWidth'(4);
                req_wdata_d = entry_q[63:32];
                bus_next    = ST_WR_START;
            end
            ST_WR_START: begin
                issue       = bus_idle;
                req_addr_d  = StartAddr;
                req_wdata_d = DataWidth'(1);
                bus_next    = ST_POLL_WAIT;
            end
            ST_POLL_RD: begin
                issue       = bus_idle;
                req_write_d = 1'b0;
                req_addr_d  = EocAddr;
                bus_next    = ST_POLL_WAIT;
            end
            default: ;
        endcase
    end

    cheshire_boot_seq_bus_if #(
        .AddrWidth (AddrWidth),
        .DataWidth (DataWidth)
    ) i_bus_if (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .issue_i     (issue),
        .write_i     (req_write_d),
        .addr_i      (req_addr_d),
        .wdata_i     (req_wdata_d),
        .req_valid_o (req_valid_o),
        .req_write_o (req_write_o),
        .req_addr_o  (req_addr_o),
        .req_wdata_o (req_wdata_o),
        .req_ready_i (req_ready_i),
        .rsp_valid_i (rsp_valid_i),
        .rsp_rdata_i (rsp_rdata_i),
        .rsp_error_i (rsp_error_i),
        .idle_o      (bus_idle),
        .rsp_done_o  (bus_done),
        .rsp_err_o   (bus_err),
        .rsp_rdata_o (bus_rdata)
    );

    // Boot flow state machine with the shared BIST-timeout / poll-interval counter.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q       <= ST_IDLE;
            entry_q       <= '0;
            cnt_q         <= '0;
            done_q        <= 1'b0;
            exit_status_q <= '0;
            err_code_q    <= ERR_NONE;
        end else begin
            case (state_q)
                ST_IDLE, ST_DONE, ST_ERROR: begin
                    if (start_i) begin
                        entry_q       <= entry_i;
                        cnt_q         <= '0;
                        done_q        <= 1'b0;
                        exit_status_q <= '0;
                        err_code_q    <= ERR_NONE;
                        state_q       <= ST_WAIT_BIST;
                    end
                end
                ST_WAIT_BIST: begin
                    // BIST completion takes priority over a timeout in the same cycle.
                    if (bist_done_i) begin
                        cnt_q   <= '0;
                        state_q <= ST_CFG_LLC;
                    end else if (cnt_q == BistTimeout - 1) begin
                        cnt_q      <= '0;
                        err_code_q <= ERR_BIST;
                        state_q    <= ST_ERROR;
                    end else begin
                        cnt_q <= cnt_q + 32'd1;
                    end
                end
                ST_CFG_LLC, ST_WR_ENTRY_LO, ST_WR_ENTRY_HI, ST_WR_START: begin
                    if (bus_err) begin
                        err_code_q <= ERR_BUS;
                        state_q    <= ST_ERROR;
                    end else if (bus_done) begin
                        cnt_q   <= '0;
                        state_q <= bus_next;
                    end
                end
                ST_POLL_WAIT: begin
                    if (cnt_q == PollCycles - 1) begin
                        cnt_q   <= '0;
                        state_q <= ST_POLL_RD;
                    end else begin
                        cnt_q <= cnt_q + 32'd1;
                    end
                end
                ST_POLL_RD: begin
                    if (bus_err) begin
                        err_code_q <= ERR_BUS;
                        state_q    <= ST_ERROR;
                    end else if (bus_done) begin
                        cnt_q <= '0;
                        if (bus_rdata[0]) begin
                            done_q        <= 1'b1;
                            exit_status_q <= bus_rdata[DataWidth-1:1];
                            state_q       <= ST_DONE;
                        end else begin
                            state_q <= bus_next;
                        end
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign busy_o        = (state_q != ST_IDLE) && (state_q != ST_DONE) && (state_q != ST_ERROR);
    assign done_o        = done_q;
    assign exit_status_o = exit_status_q;
    assign err_o         = (err_code_q != ERR_NONE);
    assign err_code_o    = err_code_q;

endmodule
